// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions: FSM state type, block size and S-box tables.
// The forward Sbox table only exists when AES_SBOX_DUAL_EN is defined.
package aes_pkg;

    localparam int AES_NB_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte 0 is the most significant byte of the 128-bit block.
    typedef logic [7:0] byte_arr_t [AES_NB_BYTES];

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

`ifdef AES_SBOX_DUAL_EN
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
`endif

endpackage

// File: rtl/aes_inv_sbox.sv
// One-byte combinational substitution lane. With AES_SBOX_DUAL_EN defined, fwd
// picks the forward Sbox; otherwise the lane is a pure InvSbox lookup.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] ip,
`ifdef AES_SBOX_DUAL_EN
    input  logic       fwd,
`endif
    output logic [7:0] op
);

`ifdef AES_SBOX_DUAL_EN
    always_comb begin
        op = fwd ? SBOX[ip] : INV_SBOX[ip];
    end
`else
    always_comb begin
        op = INV_SBOX[ip];
    end
`endif

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: LANES bytes per cycle over a latched 128-bit block.
// AES_SBOX_DUAL_EN adds a per-block fwd input selecting forward SubBytes.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] ip,
`ifdef AES_SBOX_DUAL_EN
    input  logic         fwd,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] op,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int NPASS = AES_NB_BYTES / LANES;
    localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NPASS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    byte_arr_t     blk_q, blk_d;
    byte_arr_t     op_q, op_d;
    byte_arr_t     ip_b;
`ifdef AES_SBOX_DUAL_EN
    logic          fwd_q, fwd_d;
`endif

    logic [3:0] lane_idx [LANES];
    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    for (genvar i = 0; i < AES_NB_BYTES; i++) begin : g_bytes
        assign ip_b[i]             = ip[127-8*i -: 8];
        assign op[127-8*i -: 8]    = op_q[i];
    end

    // Pass cnt covers bytes cnt*LANES .. cnt*LANES+LANES-1 of the latched block.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = 4'((int'(cnt_q) * LANES) + l);
        assign lane_in[l]  = blk_q[lane_idx[l]];

        aes_inv_sbox u_sbox (
            .ip  (lane_in[l]),
`ifdef AES_SBOX_DUAL_EN
            .fwd (fwd_q),
`endif
            .op  (lane_out[l])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        op_d      = op_q;
`ifdef AES_SBOX_DUAL_EN
        fwd_d     = fwd_q;
`endif
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: ;
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    op_d[lane_idx[l]] = lane_out[l];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An accept overrides the DONE->IDLE exit, giving back-to-back blocks.
        if (in_valid && in_ready) begin
            blk_d   = ip_b;
            cnt_d   = '0;
            state_d = BUSY;
`ifdef AES_SBOX_DUAL_EN
            fwd_d   = fwd;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '{default: 8'h00};
            op_q    <= '{default: 8'h00};
`ifdef AES_SBOX_DUAL_EN
            fwd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            op_q    <= op_d;
`ifdef AES_SBOX_DUAL_EN
            fwd_q   <= fwd_d;
`endif
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter at LANES = 4, 1 and 16; the reference S-boxes are
// derived from GF(2^8) arithmetic rather than copied tables.
module tb_inv_sub_bytes_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] ip_a        [3];
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] op_a        [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
`ifdef AES_SBOX_DUAL_EN
    logic         fwd_a       [3];
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] inv_tab [256];
    logic [7:0] fwd_tab [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Sbox(x) = affine(x^-1), with 0 mapping to 0 before the affine step.
    function automatic logic [7:0] sbox_of(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(x, 8'(b)) == 8'h01) v = 8'(b);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_block(input logic [127:0] x, input logic f);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = f ? fwd_tab[x[127-8*i -: 8]] : inv_tab[x[127-8*i -: 8]];
        end
        return r;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            fwd_tab[x]          = sbox_of(8'(x));
            inv_tab[fwd_tab[x]] = 8'(x);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        localparam int N = 16 / L;

        inv_sub_bytes_iter #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ip        (ip_a[g]),
`ifdef AES_SBOX_DUAL_EN
            .fwd       (fwd_a[g]),
`endif
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .op        (op_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g])
        );

        // Transaction model: a block accepted at an edge is ready N edges later.
        int           m_left;
        logic         m_done;
        logic [127:0] m_pend;
        logic [127:0] m_op;
        logic         m_ready;
        logic         m_fwd;

`ifdef AES_SBOX_DUAL_EN
        assign m_fwd = fwd_a[g];
`else
        assign m_fwd = 1'b0;
`endif
        assign m_ready = ((m_left == 0) && !m_done) || (m_done && out_ready_a[g]);

        always @(posedge clk) begin
            if (rst) begin
                m_left <= 0;
                m_done <= 1'b0;
            end else if (in_valid_a[g] && m_ready) begin
                m_left <= N;
                m_done <= 1'b0;
                m_pend <= sub_block(ip_a[g], m_fwd);
            end else if (m_done && out_ready_a[g]) begin
                m_done <= 1'b0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_op   <= m_pend;
                end
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                check($sformatf("L%0d in_ready", L), 128'(in_ready_a[g]), 128'(m_ready));
                check($sformatf("L%0d out_valid", L), 128'(out_valid_a[g]), 128'(m_done));
                if (m_done) check($sformatf("L%0d op", L), op_a[g], m_op);
            end
        end
    end

    task automatic wait_out(input int g, output int lat);
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid_a[g]) break;
        end
        if (!out_valid_a[g]) begin
            n_total++;
            $display("FAIL wait_out[%0d]: out_valid never rose within %0d cycles", g, lat);
        end
    endtask

    task automatic send(input int g, input logic [127:0] data, output int lat);
        @(posedge clk);
        #1;
        ip_a[g]       = data;
        in_valid_a[g] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready_a[g]) break;
        end
        if (!in_ready_a[g]) begin
            n_total++;
            $display("FAIL send[%0d]: in_ready never rose", g);
        end
        @(posedge clk);
        #1;
        in_valid_a[g] = 1'b0;
        wait_out(g, lat);
    endtask

    localparam logic [127:0] SEQ = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        int           lat;
        logic [127:0] held;

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            ip_a[g]        = '0;
            in_valid_a[g]  = 1'b0;
            out_ready_a[g] = 1'b1;
`ifdef AES_SBOX_DUAL_EN
            fwd_a[g]       = 1'b0;
`endif
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("pin inv(00)", 128'(inv_tab[8'h00]), 128'h52);
        check("pin inv(01)", 128'(inv_tab[8'h01]), 128'h09);
        check("pin inv(ed)", 128'(inv_tab[8'hed]), 128'h53);
        check("pin inv(63)", 128'(inv_tab[8'h63]), 128'h00);

        @(negedge clk);
        check("reset in_ready", 128'(in_ready_a[0]), 128'h1);
        check("reset out_valid", 128'(out_valid_a[0]), 128'h0);
        check("reset op", op_a[0], 128'h0);

        send(0, {16{8'h63}}, lat);
        check("basic latency", 128'(lat), 128'd5);
        check("basic op", op_a[0], 128'h0);

        send(0, 128'h0, lat);
        check("fips zero op", op_a[0], {16{8'h52}});
        send(0, {16{8'hed}}, lat);
        check("fips ed op", op_a[0], {16{8'h53}});

        // Backpressure: DONE held for 10 cycles, then a back-to-back accept.
        @(posedge clk);
        #1 out_ready_a[0] = 1'b0;
        send(0, 128'h00112233445566778899aabbccddeeff, lat);
        check("bp latency", 128'(lat), 128'd5);
        check("bp byte0", 128'(op_a[0][127:120]), 128'h52);
        held = op_a[0];
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp op stable", op_a[0], held);
            check("bp in_ready low", 128'(in_ready_a[0]), 128'h0);
        end
        @(posedge clk);
        #1;
        out_ready_a[0] = 1'b1;
        ip_a[0]        = 128'h0;
        in_valid_a[0]  = 1'b1;
        @(negedge clk);
        check("bp same-cycle in_ready", 128'(in_ready_a[0]), 128'h1);
        @(posedge clk);
        #1 in_valid_a[0] = 1'b0;
        wait_out(0, lat);
        check("bp next latency", 128'(lat), 128'd5);
        check("bp next op", op_a[0], {16{8'h52}});

        // Reset while BUSY with cnt = 2.
        @(posedge clk);
        #1;
        ip_a[0]       = {16{8'hed}};
        in_valid_a[0] = 1'b1;
        @(posedge clk);
        #1 in_valid_a[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst in_ready", 128'(in_ready_a[0]), 128'h1);
        for (int k = 0; k < 8; k++) begin
            check("rst no out_valid", 128'(out_valid_a[0]), 128'h0);
            @(negedge clk);
        end
        send(0, 128'h0, lat);
        check("post-rst latency", 128'(lat), 128'd5);
        check("post-rst op", op_a[0], {16{8'h52}});

        send(1, SEQ, lat);
        check("L1 latency", 128'(lat), 128'd17);
        check("L1 byte0", 128'(op_a[1][127:120]), 128'h52);
        check("L1 byte1", 128'(op_a[1][119:112]), 128'h09);
        check("L1 byte15", 128'(op_a[1][7:0]), 128'hfb);

        send(2, SEQ, lat);
        check("L16 latency", 128'(lat), 128'd2);
        check("L16 byte0", 128'(op_a[2][127:120]), 128'h52);
        check("L16 byte1", 128'(op_a[2][119:112]), 128'h09);
        check("L16 byte15", 128'(op_a[2][7:0]), 128'hfb);

`ifdef AES_SBOX_DUAL_EN
        @(posedge clk);
        #1 fwd_a[0] = 1'b1;
        send(0, 128'h0, lat);
        check("dual fwd op", op_a[0], {16{8'h63}});
        @(posedge clk);
        #1 fwd_a[0] = 1'b0;
        send(0, 128'h0, lat);
        check("dual inv op", op_a[0], {16{8'h52}});
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
